// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the instruction execution sequencer.
// Optional retired-instruction counter is enabled by macro EXEC_SEQ_RETIRE_CNT_EN.
package exec_sequencer_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } seq_state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_MOV  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b1100;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOOP = 3'b000;

  // Opcodes outside the listed set retire as NOOPs and flag illegal_op.
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_NOP, OP_MOV, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_JMP, OP_HALT: is_legal_op = 1'b1;
      default:                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving an external decoder and ALU.
// Macro EXEC_SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ack,
  output logic [INSTR_W-1:0]  ir,
  input  logic [ALU_OP_W-1:0] dec_alu_op,
  output logic                alu_en,
  output logic                rf_we,
  output logic                illegal_op,
  output logic                busy,
  output logic [CNT_W-1:0]    retired_count
);

  seq_state_t          state;
  logic [PC_WIDTH-1:0] pc;
  logic                op_legal_c;

  assign op_legal_c = is_legal_op(ir[INSTR_W-1 -: OPCODE_W]);
  assign imem_addr  = pc;

  // Strobes are set on the edge entering their state so they are registered and last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      imem_req   <= 1'b0;
      alu_en     <= 1'b0;
      rf_we      <= 1'b0;
      illegal_op <= 1'b0;
      busy       <= 1'b0;
    end else begin
      alu_en     <= 1'b0;
      rf_we      <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          state  <= S_EXEC;
          alu_en <= 1'b1;
        end
        S_EXEC: begin
          state      <= S_WB;
          rf_we      <= op_legal_c && (dec_alu_op != ALU_OP_NOOP);
          illegal_op <= !op_legal_c;
        end
        S_WB: begin
          pc <= pc + PC_WIDTH'(1);
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXEC_SEQ_RETIRE_CNT_EN
  // Every writeback retires one instruction, illegal ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (state == S_WB) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end
`else
  assign retired_count = '0;
`endif

endmodule
